// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: MMIO address map and loader state encoding.
package mem_responder_pkg;

    localparam logic [15:0] MMIO_BASE  = 16'hFFF0;
    localparam logic [15:0] ADR_STATUS = 16'hFFFD;
    localparam logic [15:0] ADR_TIMER  = 16'hFFFE;
    localparam logic [15:0] ADR_GPIO   = 16'hFFFF;

    localparam logic [1:0] LOAD_HI = 2'd0;
    localparam logic [1:0] LOAD_LO = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    function automatic logic is_ram_addr(input logic [15:0] a);
        return a < MMIO_BASE;
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Word RAM: asynchronous read, synchronous single-port write; contents are never reset.
module mem_responder_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM, MMIO window (status, timer, gpio) and a byte-serial
// boot loader that fills RAM and then releases the processor from reset.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned BOOT_WORDS = 256,
    parameter bit          BOOT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    input  logic        mw_en,
    output logic [15:0] rd_data,
    input  logic [7:0]  cpu_status,
    output logic        cpu_rst_n,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic [15:0] gpio_out,
    output logic        boot_done
);

    localparam logic [1:0]        STATE_RST     = BOOT_EN ? LOAD_HI : RUN;
    localparam logic              CPU_RST_N_RST = !BOOT_EN;
    localparam logic [ADDR_W-1:0] LAST_PTR      = ADDR_W'(BOOT_WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        status_q, status_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       gpio_q, gpio_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;

    logic              in_run;
    logic              ld_accept;
    logic              bus_we;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;

    assign in_run    = (state_q == RUN);
    assign ld_ready  = ~in_run;
    assign ld_accept = ld_valid & ld_ready;
    assign bus_we    = mw_en & in_run;

    // Loader sequencing: high byte, then low byte commits the word.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        case (state_q)
            LOAD_HI: begin
                if (ld_accept) begin
                    hi_d    = ld_data;
                    state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (ld_accept) begin
                    if (ptr_q == LAST_PTR) begin
                        state_d = RUN;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = LOAD_HI;
                    end
                end
            end
            RUN: begin
            end
            default: begin
                state_d = STATE_RST;
            end
        endcase
    end

    always_comb begin
        cpu_rst_n_d = (state_d == RUN);
        status_d    = cpu_status;

        timer_d = timer_q + 16'd1;
        if (!in_run) begin
            timer_d = '0;
        end else if (bus_we && addr == ADR_TIMER) begin
            timer_d = wr_data;
        end

        gpio_d = gpio_q;
        if (bus_we && addr == ADR_GPIO) begin
            gpio_d = wr_data;
        end
    end

    // The loader and the bus never write in the same cycle since they are gated by state.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr_q;
        ram_wdata = {hi_q, ld_data};
        if (state_q == LOAD_LO && ld_accept) begin
            ram_we = 1'b1;
        end else if (bus_we && is_ram_addr(addr)) begin
            ram_we    = 1'b1;
            ram_waddr = addr[ADDR_W-1:0];
            ram_wdata = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= STATE_RST;
            ptr_q       <= '0;
            hi_q        <= '0;
            status_q    <= '0;
            timer_q     <= '0;
            gpio_q      <= '0;
            cpu_rst_n_q <= CPU_RST_N_RST;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hi_q        <= hi_d;
            status_q    <= status_d;
            timer_q     <= timer_d;
            gpio_q      <= gpio_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    mem_responder_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(addr[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

    always_comb begin
        rd_data = '0;
        if (is_ram_addr(addr)) begin
            rd_data = ram_rdata;
        end else begin
            case (addr)
                ADR_STATUS: rd_data = {8'h00, status_q};
                ADR_TIMER:  rd_data = timer_q;
                ADR_GPIO:   rd_data = gpio_q;
                default:    rd_data = '0;
            endcase
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign boot_done = cpu_rst_n_q;
    assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: byte-count/timestamp reference model plus literal checks,
// and a second instance built with BOOT_EN=0.
module tb_mem_responder;

    localparam int BW = 4;

    logic        clk;
    logic        reset;
    logic [15:0] addr, wr_data, rd_data, gpio_out;
    logic        mw_en, cpu_rst_n, ld_valid, ld_ready, boot_done;
    logic [7:0]  cpu_status, ld_data;

    logic        reset0;
    logic [15:0] a0, wd0, rd0, gp0;
    logic        we0, crn0, lv0, ldr0, bd0;
    logic [7:0]  st0, ld0;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 0;

    mem_responder #(.ADDR_W(8), .BOOT_WORDS(BW), .BOOT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data), .mw_en(mw_en),
        .rd_data(rd_data), .cpu_status(cpu_status), .cpu_rst_n(cpu_rst_n),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .gpio_out(gpio_out), .boot_done(boot_done)
    );

    mem_responder #(.ADDR_W(8), .BOOT_WORDS(BW), .BOOT_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .addr(a0), .wr_data(wd0), .mw_en(we0),
        .rd_data(rd0), .cpu_status(st0), .cpu_rst_n(crn0),
        .ld_valid(lv0), .ld_data(ld0), .ld_ready(ldr0),
        .gpio_out(gp0), .boot_done(bd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: loading is "fewer than 2*BW bytes seen since reset";
    // the timer is a base value plus elapsed cycles since it was last set.
    logic [15:0] m_ram [256];
    bit          m_vld [256];
    int          m_nbytes, m_t0, m_cyc;
    logic [7:0]  m_hi, m_status;
    logic [15:0] m_gpio, m_tbase;

    function automatic bit m_loading();
        return m_nbytes < 2 * BW;
    endfunction

    function automatic logic [15:0] m_timer();
        if (m_loading()) return 16'h0000;
        return 16'(int'(m_tbase) + (m_cyc - m_t0));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_nbytes = 0;
            m_hi     = '0;
            m_gpio   = '0;
            m_status = '0;
            m_tbase  = '0;
            m_t0     = 0;
        end else begin
            m_cyc++;
            if (m_loading()) begin
                if (ld_valid) begin
                    if (m_nbytes % 2 == 0) m_hi = ld_data;
                    else begin
                        m_ram[m_nbytes / 2] = {m_hi, ld_data};
                        m_vld[m_nbytes / 2] = 1'b1;
                    end
                    m_nbytes++;
                    if (!m_loading()) begin
                        m_tbase = '0;
                        m_t0    = m_cyc;
                    end
                end
            end else if (mw_en) begin
                if (addr < 16'hFFF0) begin
                    m_ram[addr[7:0]] = wr_data;
                    m_vld[addr[7:0]] = 1'b1;
                end else if (addr == 16'hFFFE) begin
                    m_tbase = wr_data;
                    m_t0    = m_cyc;
                end else if (addr == 16'hFFFF) begin
                    m_gpio = wr_data;
                end
            end
            m_status = cpu_status;
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] e;
        bit          known;
        if (chk_en) begin
            chk("ld_ready", {15'd0, ld_ready}, {15'd0, m_loading()});
            chk("cpu_rst_n", {15'd0, cpu_rst_n}, {15'd0, !m_loading()});
            chk("boot_done", {15'd0, boot_done}, {15'd0, !m_loading()});
            chk("gpio_out", gpio_out, m_gpio);
            known = 1'b1;
            e     = 16'h0000;
            if (addr < 16'hFFF0) begin
                known = m_vld[addr[7:0]];
                e     = m_ram[addr[7:0]];
            end else if (addr == 16'hFFFD) e = {8'h00, m_status};
            else if (addr == 16'hFFFE) e = m_timer();
            else if (addr == 16'hFFFF) e = m_gpio;
            if (known) chk("rd_data", rd_data, e);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        cyc();
        ld_valid = 1'b0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        mw_en   = 1'b1;
        cyc();
        mw_en   = 1'b0;
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    addr = {8'($urandom), 4'h0, 4'($urandom)};
                2:       addr = 16'hFFF0 | 16'($urandom_range(0, 15));
                default: addr = 16'($urandom_range(0, 3));
            endcase
            wr_data    = 16'($urandom);
            mw_en      = ($urandom_range(0, 2) == 0);
            cpu_status = 8'($urandom);
            ld_valid   = $urandom_range(0, 1) == 1;
            ld_data    = 8'($urandom);
            cyc();
        end
        mw_en    = 1'b0;
        ld_valid = 1'b0;
    endtask

    logic [7:0] boot_bytes [8];

    initial begin
        boot_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        addr = 16'h0000; wr_data = '0; mw_en = 0; cpu_status = '0; ld_valid = 0; ld_data = '0;
        a0 = 16'hFFFE; wd0 = '0; we0 = 0; st0 = '0; lv0 = 0; ld0 = '0;
        reset = 1'b1; reset0 = 1'b1;
        #1;
        reset = 1'b0; reset0 = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("rst ld_ready", {15'd0, ld_ready}, 16'd1);
        chk("rst cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        chk("rst gpio", gpio_out, 16'h0000);
        chk("rst bd0", {15'd0, bd0}, 16'd1);
        chk("rst ldr0", {15'd0, ldr0}, 16'd0);
        chk("rst crn0", {15'd0, crn0}, 16'd1);
        addr = 16'hFFFE; #1 chk("rst timer", rd_data, 16'h0000);
        addr = 16'hFFFD; #1 chk("rst status", rd_data, 16'h0000);
        cyc(); cyc();
        reset = 1'b1;

        // Stall then reset mid-word; the half-received AB must be dropped.
        send(8'hAB);
        for (int i = 0; i < 5; i++) begin
            ld_data = 8'($urandom);
            cyc();
        end
        chk("stall cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        reset = 1'b0;
        #1 chk("midload rst cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        cyc();
        reset = 1'b1;
        send(8'h11);
        send(8'h22);
        addr = 16'h0000;
        #1 chk("restart ram0", rd_data, 16'h1122);
        chk("restart cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);

        // Full boot with random gaps.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                ld_data = 8'($urandom);
                cyc();
            end
            if (i == 7) chk("pre last cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
            send(boot_bytes[i]);
        end
        chk("boot ld_ready", {15'd0, ld_ready}, 16'd0);
        chk("boot cpu_rst_n", {15'd0, cpu_rst_n}, 16'd1);
        chk("boot done", {15'd0, boot_done}, 16'd1);
        addr = 16'h0001; #1 chk("boot ram1", rd_data, 16'h5678);
        addr = 16'h0003; #1 chk("boot ram3", rd_data, 16'hDEF0);

        bus_wr(16'h0005, 16'hCAFE);
        addr = 16'h0005; #1 chk("ram wr", rd_data, 16'hCAFE);
        addr = 16'h0105; #1 chk("ram alias", rd_data, 16'hCAFE);
        bus_wr(16'hFFF3, 16'h1234);
        addr = 16'hFFF3; #1 chk("hole read", rd_data, 16'h0000);

        bus_wr(16'hFFFE, 16'hFFFE);
        addr = 16'hFFFE;
        #1 chk("timer load", rd_data, 16'hFFFE);
        cyc(); chk("timer +1", rd_data, 16'hFFFF);
        cyc(); chk("timer wrap", rd_data, 16'h0000);

        bus_wr(16'hFFFF, 16'h00A5);
        chk("gpio wr", gpio_out, 16'h00A5);
        cpu_status = 8'h3C;
        addr = 16'hFFFD;
        cyc();
        chk("status", rd_data, 16'h003C);
        bus_wr(16'hFFFD, 16'h9999);
        addr = 16'hFFFD;
        #1 chk("status ro", rd_data, 16'h003C);
        chk("gpio hold", gpio_out, 16'h00A5);

        random_run(300);

        // Asynchronous reset in RUN.
        reset = 1'b0;
        #1;
        chk("run rst cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        chk("run rst ld_ready", {15'd0, ld_ready}, 16'd1);
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) cyc();
            send(8'($urandom));
        end
        random_run(150);

        // BOOT_EN=0 instance.
        a0 = 16'hFFFE;
        cyc();
        reset0 = 1'b1;
        #1 chk("b0 timer0", rd0, 16'h0000);
        cyc(); chk("b0 timer1", rd0, 16'h0001);
        cyc(); chk("b0 timer2", rd0, 16'h0002);
        chk("b0 cpu_rst_n", {15'd0, crn0}, 16'd1);
        chk("b0 boot_done", {15'd0, bd0}, 16'd1);
        a0 = 16'h0000; wd0 = 16'h1357; we0 = 1'b1;
        cyc();
        we0 = 1'b0; lv0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ld0 = 8'($urandom);
            cyc();
        end
        lv0 = 1'b0;
        #1 chk("b0 ld ignored", rd0, 16'h1357);
        chk("b0 ld_ready", {15'd0, ldr0}, 16'd0);

        cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 16-bit RISC processor bus. It serves instruction/data reads and writes over Address, D_out and mw_en, and returns read data on D_in.
- Contains a word RAM, a small memory-mapped I/O window (free-running timer, GPIO output register, processor status sample) and a byte-serial boot loader.
- The boot loader fills RAM before releasing the processor from reset.
- Sits beside the processor at the top level: processor outputs drive this block's bus inputs, and this block's rd_data drives the processor's D_in.

Parameters:
- ADDR_W, 8, RAM word-address width; RAM depth = 2**ADDR_W words.
- BOOT_WORDS, 256, number of 16-bit words the loader writes before releasing the CPU; range 1..2**ADDR_W.
- BOOT_EN, 1, 1 = start in load mode; 0 = start directly in RUN (RAM preloaded by simulation/init).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- addr  in  16  processor Address
- wr_data  in  16  processor D_out (store data)
- mw_en  in  1  processor memory write enable
- rd_data  out  16  read data to processor D_in
- cpu_status  in  8  processor Status bus
- cpu_rst_n  out  1  active-low reset to processor; low while loading
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_ready  out  1  loader can accept a byte
- gpio_out  out  16  GPIO output register
- boot_done  out  1  high once in RUN

Behaviour:
- Address map:
  - addr < 16'hFFF0: RAM, index = addr[ADDR_W-1:0]; higher bits ignored (aliasing).
  - 16'hFFFD: status sample, read-only; writes ignored.
  - 16'hFFFE: timer, read/write.
  - 16'hFFFF: gpio, read/write.
  - 16'hFFF0..FFFC: reads return 0, writes ignored.
- Reads are combinational, with zero latency: rd_data reflects addr in the same cycle, because the processor fetches single-cycle.
- Writes commit on the rising edge when mw_en=1 and state=RUN. Bus writes in load states are ignored.
- Status sample register: captures cpu_status every cycle; a read returns {8'h00, sample}.
- Timer:
  - 16-bit, increments by 1 every cycle in RUN; holds at 0 in load states.
  - Wraps from FFFF to 0000.
  - A bus write to FFFE loads wr_data and overrides that cycle's increment; the next cycle counts from the loaded value.
- gpio_out: updated from wr_data on a write to FFFF; otherwise holds.
- Loader FSM states: LOAD_HI, LOAD_LO, RUN.
  - Reset: state = LOAD_HI if BOOT_EN=1, else RUN; word pointer = 0.
  - ld_ready = 1 in LOAD_HI/LOAD_LO, 0 in RUN. A byte is accepted when ld_valid && ld_ready.
  - LOAD_HI + accept: latch byte as hi, go to LOAD_LO.
  - LOAD_LO + accept: ram[ptr] <= {hi, ld_data}. If ptr == BOOT_WORDS-1, go to RUN; else ptr++ and go to LOAD_HI.
  - No accept: hold state. ld_valid in RUN is ignored.
- cpu_rst_n and boot_done:
  - cpu_rst_n is registered: 0 in load states, 1 from the first cycle the state is RUN.
  - boot_done equals cpu_rst_n.
- Reset values: rd_data combinational (RAM content); cpu_rst_n=0 (1 if BOOT_EN=0); ld_ready = BOOT_EN; gpio_out=0; boot_done = ~BOOT_EN; timer=0; status sample=0; ptr=0; hi=0.
- RAM array is not reset; its contents survive reset.
- Reset asserted mid-load: the FSM restarts at LOAD_HI with ptr=0 and any half-received word is discarded. Words already written remain but are overwritten by the new stream.
- Reset in RUN: returns to load mode (if BOOT_EN) and reasserts cpu_rst_n immediately, because reset is asynchronous.
- Pointer width is ADDR_W bits. With BOOT_WORDS = 2**ADDR_W the final word is written at the all-ones index and no wrap occurs.

Decomposition:
- Shared package holds:
  - MMIO address constants: MMIO_BASE=16'hFFF0, ADR_STATUS=16'hFFFD, ADR_TIMER=16'hFFFE, ADR_GPIO=16'hFFFF.
  - Loader state encoding: LOAD_HI=2'd0, LOAD_LO=2'd1, RUN=2'd2.
- One natural sub-module, mem_responder_ram: depth 2**ADDR_W, async read, synchronous write. It has two write sources, loader and bus, muxed in the parent by state.

Test Plan:
- Boot, BOOT_WORDS=4: bytes 12,34,56,78,9A,BC,DE,F0 each with ld_valid=1 -> ram[0..3] = 1234, 5678, 9ABC, DEF0. ld_ready drops and cpu_rst_n/boot_done rise the cycle after byte 8. addr=0001 -> rd_data=5678.
- Loader stall plus mid-load reset: send AB, hold ld_valid=0 for 5 cycles, pulse reset low, then send 11,22 -> ram[0]=1122. cpu_rst_n stays 0 throughout.
- RUN bus access: write addr=0005 data=CAFE, then read 0005 -> CAFE. Read 0105 -> CAFE (alias, ADDR_W=8). Write FFF3 -> no effect and reads 0.
- Timer: after boot, read FFFE on successive cycles -> increments by 1. Write FFFE=FFFE -> reads FFFE, FFFF, 0000 over the next three cycles.
- GPIO/status: write FFFF=00A5 -> gpio_out=00A5 next edge. cpu_status=3C -> FFFD reads 003C the cycle after. Write to FFFD -> ignored.
- BOOT_EN=0: out of reset cpu_rst_n=1, ld_ready=0, ld_valid bytes ignored, timer counts from 0.
